// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers returned words with
// their PC in a small FIFO, and hands them to decode; a redirect flushes and squashes.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  // Cap on live + stale requests at the memory so back-to-back redirects cannot
  // overflow the discard counter.
  localparam int OUT_MAX = 4 * DEPTH;
  localparam int DISC_W  = $clog2(OUT_MAX + 1);
  localparam int SUM_W   = DISC_W + 1;

  logic             run_q;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      resp_pc_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] count_q;
  logic [DISC_W-1:0] discard_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];

  logic             req_fire;
  logic             rsp_live;
  logic             rsp_drop;
  logic             pop;
  logic [SUM_W-1:0] fifo_claim;
  logic [SUM_W-1:0] outstanding;

  assign inst_valid = (count_q != '0);
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign pop        = inst_valid & inst_ready;

  // inflight counts only live requests; a pop this cycle frees a slot before any
  // new response can land, which keeps one instruction per cycle in steady state.
  assign fifo_claim  = SUM_W'(inflight_q) + SUM_W'(count_q) - SUM_W'(pop);
  assign outstanding = SUM_W'(inflight_q) + SUM_W'(discard_q);

  assign imem_req_valid = run_q & ~redirect_valid &
                          (fifo_claim < SUM_W'(DEPTH)) &
                          (outstanding < SUM_W'(OUT_MAX));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (discard_q != '0);
  assign rsp_live = imem_rsp_valid & (discard_q == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        resp_pc_q  <= {redirect_pc[31:2], 2'b00};
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        inflight_q <= '0;
        // Every request still out becomes stale; a response landing now is dropped too.
        discard_q  <= discard_q + DISC_W'(inflight_q) - DISC_W'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        inflight_q <= inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
        if (rsp_drop) begin
          discard_q <= discard_q - DISC_W'(1);
        end
        if (rsp_live) begin
          pc_mem_q[wr_ptr_q]   <= resp_pc_q;
          data_mem_q[wr_ptr_q] <= imem_rsp_data;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
          resp_pc_q            <= resp_pc_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(rsp_live) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected (pc, word) pairs filled as requests are accepted.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Clock / watchdog
  initial forever #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          delivered = 0;
  bit          rdy_dec = 1'b0;
  bit          mem_rand = 1'b0;
  bit          prev_redirect = 1'b0;
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check_eq({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check_eq({tag, "_inst_data"}, inst_data, 32'd0);
    check_eq({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  // Driver + monitor for one cycle: drive after the falling edge, settle, then account
  // for the handshakes that the next rising edge will complete.
  task automatic step(input bit rdr_v, input logic [31:0] rdr_pc);
    logic [31:0] e;
    int          due;
    @(negedge CLK);
    redirect_valid = rdr_v;
    redirect_pc    = rdr_pc;
    inst_ready     = rdy_dec;
    imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    if (prev_redirect) begin
      check_eq("inst_valid_after_redirect", 32'(inst_valid), 32'd0);
      if (!rdr_v) check_eq("req_after_redirect", 32'(imem_req_valid), 32'd1);
    end
    if (rdr_v) begin
      check_eq("req_in_redirect", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_next = {rdr_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check_eq("req_addr", imem_req_addr, exp_next);
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(due);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_inst", 32'(inst_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("inst_pc", inst_pc, e);
          check_eq("inst_data", inst_data, mem_word(e));
          delivered++;
        end
      end
    end
    prev_redirect = rdr_v;
    cyc++;
  endtask

  initial begin
    int d0;

    // Reset / startup with decode stalled
    repeat (5) step(1'b0, '0);
    check_reset_outputs("reset");
    RST = 1'b1;
    check_eq("req_before_run", 32'(imem_req_valid), 32'd0);
    step(1'b0, '0);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);

    // Backpressure: only DEPTH requests may be outstanding
    repeat (9) step(1'b0, '0);
    check_eq("bp_outstanding", 32'(exp_q.size()), 32'(DEPTH));
    check_eq("bp_valid", 32'(inst_valid), 32'd1);
    check_eq("bp_head_pc", inst_pc, RESET_PC);

    // Release and measure steady-state throughput
    rdy_dec = 1'b1;
    repeat (10) step(1'b0, '0);
    d0 = delivered;
    repeat (10) step(1'b0, '0);
    check_eq("throughput", 32'(delivered - d0), 32'd10);

    // Random memory stalls, latency, decode stalls and occasional redirects
    mem_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      lat     = $urandom_range(1, 3);
      rdy_dec = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) step(1'b1, $urandom());
      else                            step(1'b0, '0);
    end

    // Redirect while two requests are in flight
    mem_rand = 1'b0;
    rdy_dec  = 1'b1;
    lat      = 2;
    for (int i = 0; i < 50 && mq_addr.size() != 2; i++) step(1'b0, '0);
    check_eq("inflight2_reached", 32'(mq_addr.size()), 32'd2);
    step(1'b1, 32'h0000_0100);
    repeat (15) step(1'b0, '0);

    // Redirect coinciding with a response and a pop, unaligned target
    lat = 1;
    repeat (10) step(1'b0, '0);
    step(1'b1, 32'h0000_0203);
    check_eq("coincide_setup", {30'd0, imem_rsp_valid, inst_valid}, 32'd3);
    repeat (10) step(1'b0, '0);

    // Address wrap-around
    step(1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b0, '0);

    // Back-to-back redirects with stale requests outstanding
    lat = 3;
    repeat (4) step(1'b0, '0);
    step(1'b1, 32'h0000_0300);
    step(1'b1, 32'h0000_0400);
    repeat (20) step(1'b0, '0);

    // Reset mid-stream with buffered instructions
    rdy_dec = 1'b0;
    step(1'b1, 32'h0000_0500);
    for (int i = 0; i < 30 && !(inst_valid && exp_q.size() == DEPTH); i++) step(1'b0, '0);
    check_eq("pre_reset_valid", 32'(inst_valid), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    mq_addr.delete();
    mq_due.delete();
    last_due      = 0;
    exp_next      = RESET_PC;
    prev_redirect = 1'b0;
    lat           = 1;
    repeat (3) step(1'b0, '0);
    RST     = 1'b1;
    rdy_dec = 1'b1;
    d0 = delivered;
    repeat (15) step(1'b0, '0);
    check_eq("restart_delivered", 32'(delivered - d0 > 8), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
